// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Optional performance counters in the top are enabled with DMEM_ARB_PERF_EN.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_0,
        OWN_1
    } owner_e;

    localparam int REQ_LSU  = 0;
    localparam int REQ_HOST = 1;
    localparam int DMEM_AW  = 32;
    localparam int DMEM_DW  = 32;

endpackage

// File: rtl/dmem_rd_tag_pipe.sv
// Read-tag delay line: carries a valid bit and the requester id of each accepted
// read so they surface in the same cycle the memory returns the data.
module dmem_rd_tag_pipe
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic push_vld,
    input  logic push_id,
    output logic tap_vld,
    output logic tap_id
);

    logic [DEPTH-1:0] vld_p;
    logic [DEPTH-1:0] id_p;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= push_vld;
            for (int s = 1; s < DEPTH; s++) begin
                vld_p[s] <= vld_p[s-1];
            end
        end
    end

    // Ids are only meaningful alongside a set valid bit, so they are not reset.
    always_ff @(posedge clk) begin
        id_p[0] <= push_id;
        for (int s = 1; s < DEPTH; s++) begin
            id_p[s] <= id_p[s-1];
        end
    end

    assign tap_vld = vld_p[DEPTH-1];
    assign tap_id  = id_p[DEPTH-1];

endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter with bounded burst lock sharing one data-memory port between
// the LSU (port 0) and the host loader (port 1). Define DMEM_ARB_PERF_EN for perf counters.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int READ_LATENCY   = 1,
    parameter int MAX_LOCK_BEATS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req,
    input  logic [1:0]         we,
    input  logic [1:0]         lock,
    input  logic [DMEM_AW-1:0] addr0,
    input  logic [DMEM_AW-1:0] addr1,
    input  logic [DMEM_DW-1:0] wdata0,
    input  logic [DMEM_DW-1:0] wdata1,
    output logic [1:0]         gnt,
    output logic [1:0]         rvalid,
    output logic [DMEM_DW-1:0] rdata,
    output logic [DMEM_AW-1:0] mem_addr,
    output logic [DMEM_DW-1:0] mem_wdata,
    output logic               mem_we,
    output logic               mem_re,
`ifdef DMEM_ARB_PERF_EN
    output logic [31:0]        perf_grants0,
    output logic [31:0]        perf_grants1,
    output logic [31:0]        perf_conflicts,
`endif
    input  logic [DMEM_DW-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MAX_LOCK_BEATS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK_BEATS);

    owner_e           owner;
    owner_e           owner_nxt;
    logic             last;
    logic             last_nxt;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       gnt_c;
    logic             own_id;
    logic             open_arb;
    logic             gsel;
    logic             any_gnt;
    logic             tap_vld;
    logic             tap_id;

    // On a tie the requester given by pri wins; single requests pass straight through.
    function automatic logic [1:0] pick(input logic [1:0] r, input logic pri);
        if (r == 2'b11) begin
            return pri ? 2'b10 : 2'b01;
        end
        return r;
    endfunction

    always_comb begin
        gnt_c     = 2'b00;
        owner_nxt = owner;
        last_nxt  = last;
        cnt_nxt   = lock_cnt;
        own_id    = (owner == OWN_1);
        open_arb  = 1'b0;
        case (owner)
            OWN_0, OWN_1: begin
                // At the beat limit the owner already equals last, so an open
                // round-robin pass hands any tie to the waiting requester.
                if (lock_cnt >= CNT_MAX) begin
                    open_arb = 1'b1;
                end else if (!req[own_id]) begin
                    owner_nxt = OWN_NONE;
                    cnt_nxt   = '0;
                end else begin
                    gnt_c[own_id] = 1'b1;
                    if (lock[own_id]) begin
                        cnt_nxt = lock_cnt + 1'b1;
                    end else begin
                        owner_nxt = OWN_NONE;
                        cnt_nxt   = '0;
                    end
                end
            end
            default: open_arb = 1'b1;
        endcase
        if (open_arb) begin
            gnt_c     = pick(req, ~last);
            owner_nxt = OWN_NONE;
            cnt_nxt   = '0;
            if (gnt_c != 2'b00) begin
                last_nxt = gnt_c[REQ_HOST];
                if (lock[gnt_c[REQ_HOST]]) begin
                    owner_nxt = gnt_c[REQ_HOST] ? OWN_1 : OWN_0;
                    cnt_nxt   = CNT_W'(1);
                end
            end
        end
        if (reset) begin
            gnt_c = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner    <= OWN_NONE;
            last     <= 1'b1;
            lock_cnt <= '0;
        end else begin
            owner    <= owner_nxt;
            last     <= last_nxt;
            lock_cnt <= cnt_nxt;
        end
    end

    assign gnt       = gnt_c;
    assign any_gnt   = |gnt_c;
    assign gsel      = gnt_c[REQ_HOST];
    assign mem_addr  = any_gnt ? (gsel ? addr1 : addr0) : '0;
    assign mem_wdata = any_gnt ? (gsel ? wdata1 : wdata0) : '0;
    assign mem_we    = any_gnt & we[gsel];
    assign mem_re    = any_gnt & ~we[gsel];

    dmem_rd_tag_pipe #(
        .DEPTH(READ_LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .push_vld(mem_re),
        .push_id (gsel),
        .tap_vld (tap_vld),
        .tap_id  (tap_id)
    );

    // Tags arrive aligned with mem_rdata, so data is forwarded without a register.
    assign rvalid = reset ? 2'b00 : {tap_vld & tap_id, tap_vld & ~tap_id};
    assign rdata  = (tap_vld && !reset) ? mem_rdata : '0;

`ifdef DMEM_ARB_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != '1)) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_grants0   <= '0;
            perf_grants1   <= '0;
            perf_conflicts <= '0;
        end else begin
            perf_grants0   <= sat_inc(perf_grants0, gnt_c[REQ_LSU]);
            perf_grants1   <= sat_inc(perf_grants1, gnt_c[REQ_HOST]);
            perf_conflicts <= sat_inc(perf_conflicts, req == 2'b11);
        end
    end
`endif

endmodule
